// File: rtl/ram_byte_view_if.sv
// Front-panel bus for ram_byte_view: address/write/byte-enable/data and LED select in,
// registered read word, LED byte and clear-busy flag out.
interface ram_byte_view_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
);
  localparam int NB    = DATA_W / 8;
  localparam int SEL_W = $clog2(NB);

  logic [ADDR_W-1:0] Mem_Addr;
  logic              Mem_Write;
  logic [NB-1:0]     Byte_En;
  logic [DATA_W-1:0] W_Data;
  logic [SEL_W-1:0]  C;
  logic              Scan;
  logic [DATA_W-1:0] R_Data;
  logic [7:0]        LED;
  logic              Busy;

  modport master (
    output Mem_Addr, Mem_Write, Byte_En, W_Data, C, Scan,
    input  R_Data, LED, Busy
  );

  modport slave (
    input  Mem_Addr, Mem_Write, Byte_En, W_Data, C, Scan,
    output R_Data, LED, Busy
  );
endinterface

// File: rtl/ram_byte_view.sv
// Single-port byte-enable word RAM with registered read, self-clear after reset and an
// 8-bit LED byte viewer. Define RAM_SCAN_EN to build the automatic byte-scan option.
module ram_byte_view #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 4
) (
  input  logic           Clk,
  input  logic           Rst,
  ram_byte_view_if.slave bus
);
  localparam int NB    = DATA_W / 8;
  localparam int SEL_W = $clog2(NB);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [SEL_W-1:0]  sel;

  // Control FSM: walk the clear pointer over every word, then serve reads.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= CLEAR;
      ptr        <= '0;
      bus.Busy   <= 1'b1;
      bus.R_Data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state    <= IDLE;
            bus.Busy <= 1'b0;
          end
        end
        IDLE:    bus.R_Data <= mem[bus.Mem_Addr];
        default: state <= CLEAR;
      endcase
    end
  end

  // Storage: clear writes win while busy; user writes are per-byte and read-first.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == CLEAR) begin
        mem[ptr] <= '0;
      end else if (bus.Mem_Write) begin
        for (int i = 0; i < NB; i++) begin
          if (bus.Byte_En[i]) mem[bus.Mem_Addr][8*i +: 8] <= bus.W_Data[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_SCAN_EN
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_cnt;
  logic [SEL_W-1:0] byte_cnt;

  // Counters idle at zero whenever scan is off, so a new scan always starts at byte 0.
  always_ff @(posedge Clk) begin
    if (Rst || !bus.Scan) begin
      div_cnt  <= '0;
      byte_cnt <= '0;
    end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
      div_cnt  <= '0;
      byte_cnt <= (byte_cnt == SEL_W'(NB - 1)) ? '0 : byte_cnt + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign sel = bus.Scan ? byte_cnt : bus.C;
`else
  logic scan_unused;
  assign scan_unused = bus.Scan ^ (SCAN_DIV > 0);
  assign sel = bus.C;
`endif

  // Selects beyond the last byte (non-power-of-2 NB) leave the LEDs dark.
  always_comb begin
    bus.LED = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (sel == SEL_W'(i)) bus.LED = bus.R_Data[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_ram_byte_view.sv
// Randomised and directed bench for ram_byte_view against a behavioural word/byte model.
module tb_ram_byte_view;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 32;
  localparam int SCAN_DIV = 4;
  localparam int NB       = DATA_W / 8;
  localparam int DEPTH    = 2 ** ADDR_W;
`ifdef RAM_SCAN_EN
  localparam bit SCAN_EN = 1'b1;
`else
  localparam bit SCAN_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  ram_byte_view_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_byte_view #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [DATA_W-1:0] m_mem [DEPTH];
  logic [DATA_W-1:0] m_rd;
  int                m_clear_left;
  int                m_scan_edges;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_led();
    int s;
    if (SCAN_EN && bus.Scan) s = (m_scan_edges / SCAN_DIV) % NB;
    else                     s = int'(bus.C);
    if (s >= NB) return 8'h00;
    return 8'((m_rd >> (8 * s)) & 32'hFF);
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".busy"}, {31'b0, bus.Busy}, {31'b0, (m_clear_left > 0)});
    check({tag, ".rdata"}, bus.R_Data, m_rd);
    check({tag, ".led"}, {24'b0, bus.LED}, {24'b0, exp_led()});
  endtask

  // One clock: model reacts to the inputs presented, then outputs are compared.
  task automatic step(input string tag);
    @(posedge Clk);
    if (Rst) begin
      m_clear_left = DEPTH;
      m_rd         = '0;
      m_scan_edges = 0;
    end else begin
      m_scan_edges = bus.Scan ? m_scan_edges + 1 : 0;
      if (m_clear_left > 0) begin
        m_mem[DEPTH - m_clear_left] = '0;
        m_clear_left--;
      end else begin
        m_rd = m_mem[bus.Mem_Addr];
        if (bus.Mem_Write)
          for (int i = 0; i < NB; i++)
            if (bus.Byte_En[i]) m_mem[bus.Mem_Addr][8*i +: 8] = bus.W_Data[8*i +: 8];
      end
    end
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic [ADDR_W-1:0] a, input logic we, input logic [NB-1:0] be,
                       input logic [DATA_W-1:0] d);
    bus.Mem_Addr  = a;
    bus.Mem_Write = we;
    bus.Byte_En   = be;
    bus.W_Data    = d;
  endtask

  // Steps until Busy falls; returns the number of cycles it stayed high.
  task automatic count_busy(input string tag, output int n);
    n = 0;
    while (bus.Busy && n < 200) begin
      step(tag);
      n++;
    end
  endtask

  logic [7:0] led_exp_tbl [4];
  int n;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_rd = '0; m_clear_left = DEPTH; m_scan_edges = 0;
    led_exp_tbl[0] = 8'h78; led_exp_tbl[1] = 8'h56;
    led_exp_tbl[2] = 8'h34; led_exp_tbl[3] = 8'h12;
    Rst = 1'b1;
    drive('0, 1'b0, '0, '0);
    bus.C = '0; bus.Scan = 1'b0;

    // Reset, then the clear sequence
    step("reset");
    check("reset.busy_hi", {31'b0, bus.Busy}, 32'd1);
    check("reset.rdata0", bus.R_Data, 32'h0);
    Rst = 1'b0;
    count_busy("clear", n);
    check("clear.busy_cycles", n, 32'd64);
    for (int a = 0; a < DEPTH; a++) begin
      drive(ADDR_W'(a), 1'b0, '0, '0);
      step("readall");
      check("readall.zero", bus.R_Data, 32'h0);
    end

    // Full-word write and LED byte select
    drive(6'h20, 1'b1, 4'hF, 32'h12345678);
    step("wr20");
    drive(6'h20, 1'b0, 4'h0, 32'h0);
    step("rd20");
    check("rd20.word", bus.R_Data, 32'h12345678);
    for (int c = 0; c < 4; c++) begin
      bus.C = 2'(c);
      #1;
      check("led_c", {24'b0, bus.LED}, {24'b0, led_exp_tbl[c]});
      check_outputs("led_c_model");
    end

    // Single-byte write
    drive(6'h20, 1'b1, 4'b0100, 32'hAABBCCDD);
    step("wrbyte");
    drive(6'h20, 1'b0, 4'h0, 32'h0);
    step("rdbyte");
    check("rdbyte.word", bus.R_Data, 32'h12BB5678);

    // Byte_En=0 write is a no-op
    drive(6'h20, 1'b1, 4'h0, 32'hFFFFFFFF);
    step("wrnone");
    step("rdnone");
    check("rdnone.word", bus.R_Data, 32'h12BB5678);

    // Read-during-write at the same address is read-first
    drive(6'h05, 1'b1, 4'hF, 32'hCAFEF00D);
    step("rdw");
    check("rdw.old", bus.R_Data, 32'h0);
    drive(6'h05, 1'b0, 4'h0, 32'h0);
    step("rdw2");
    check("rdw.new", bus.R_Data, 32'hCAFEF00D);

    // LED scan (or, without the option, Scan has no effect)
    drive(6'h20, 1'b1, 4'hF, 32'h12345678);
    step("wrscan");
    drive(6'h20, 1'b0, 4'h0, 32'h0);
    bus.C = 2'd2;
    step("rdscan");
    bus.Scan = 1'b1;
    #1;
    check("scan.start", {24'b0, bus.LED}, SCAN_EN ? 32'h78 : 32'h34);
    for (int k = 1; k <= 4 * NB + 2; k++) begin
      step("scan");
      check("scan.seq", {24'b0, bus.LED},
            {24'b0, SCAN_EN ? led_exp_tbl[(k / SCAN_DIV) % NB] : 8'h34});
    end
    bus.Scan = 1'b0;
    bus.C = 2'd1;
    step("scan_off");
    check("scan_off.led", {24'b0, bus.LED}, 32'h56);

    // Reset in the middle of the clear, with a write attempted while busy
    Rst = 1'b1;
    step("rst2");
    Rst = 1'b0;
    for (int k = 0; k < 10; k++) step("clear2");
    Rst = 1'b1;
    step("rst3");
    Rst = 1'b0;
    drive(6'h00, 1'b1, 4'hF, 32'hDEADBEEF);
    count_busy("clear3", n);
    check("clear3.busy_cycles", n, 32'd64);
    drive(6'h00, 1'b0, 4'h0, 32'h0);
    step("rd0");
    check("rd0.zero", bus.R_Data, 32'h0);

    // Random traffic against the model; narrow address range forces reuse
    for (int k = 0; k < 600; k++) begin
      drive(ADDR_W'($urandom_range(0, 7) + ((k % 50 == 0) ? $urandom_range(0, 56) : 0)),
            1'($urandom_range(0, 1)), NB'($urandom), DATA_W'($urandom));
      bus.C = 2'($urandom);
      if ($urandom_range(0, 19) == 0) bus.Scan = ~bus.Scan;
      Rst = ($urandom_range(0, 299) == 0);
      step("rand");
    end
    Rst = 1'b0;
    bus.Mem_Write = 1'b0;
    count_busy("rand_tail", n);
    step("rand_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
